// File: rtl/clken_gen_frac.sv
// clken_gen_frac: N-channel fractional clock-enable generator with glitch-free retune and lock sequencer
module clken_gen_frac #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 16,
  parameter logic [NUM_CH*ACC_W-1:0] DEF_INC = {16'd13, 16'd26},
  parameter logic [NUM_CH*ACC_W-1:0] DEF_MOD = {16'd27, 16'd27},
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
  input  logic              i_refclk,
  input  logic              i_rst_n,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [ACC_W-1:0]  i_cfg_inc,
  input  logic [ACC_W-1:0]  i_cfg_mod,
  input  logic              i_phase_sync,
  output logic [NUM_CH-1:0] o_ce,
  output logic              o_cfg_busy,
  output logic              o_locked
);
  typedef enum logic {SETTLE, LOCKED} state_t;
  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0] w_pend;
  logic w_we_ok;
  // writes to a nonexistent channel are dropped everywhere, including the lock sequencer
  assign w_we_ok = i_cfg_we && ({1'b0, i_cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign o_cfg_busy = |w_pend;
  assign o_locked = (r_state == LOCKED);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] r_acc, r_inc, r_mod, r_pinc, r_pmod;
    logic r_pend, r_ce;
    logic [ACC_W:0] w_sum, w_dif;
    logic w_clamp, w_dis, w_fire, w_apply, w_wr;
    // a channel fires when the widened sum crosses MOD; INC>=MOD (incl. MOD==0) clamps, INC==0 freezes
    always_comb begin
      w_sum = {1'b0, r_acc} + {1'b0, r_inc};
      w_dif = w_sum - {1'b0, r_mod};
      w_clamp = r_inc >= r_mod;
      w_dis = !w_clamp && r_inc == '0;
      w_fire = w_clamp || (!w_dis && w_sum >= {1'b0, r_mod});
      w_apply = r_pend && !i_phase_sync && (w_fire || w_dis);
      w_wr = w_we_ok && i_cfg_ch == CH_W'(g);
    end
    // accumulator, registered enable and pending config; retune only on a pulse boundary
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_acc <= '0;
        r_ce <= 1'b0;
        r_inc <= DEF_INC[g*ACC_W +: ACC_W];
        r_mod <= DEF_MOD[g*ACC_W +: ACC_W];
        r_pinc <= '0;
        r_pmod <= '0;
        r_pend <= 1'b0;
      end else begin
        r_acc <= (i_phase_sync || w_clamp) ? '0 : w_dis ? r_acc : ACC_W'(w_fire ? w_dif : w_sum);
        r_ce <= !i_phase_sync && w_fire;
        if (w_apply) begin
          r_inc <= r_pinc;
          r_mod <= r_pmod;
        end
        if (w_wr) begin
          r_pinc <= i_cfg_inc;
          r_pmod <= i_cfg_mod;
        end
        r_pend <= w_wr || (r_pend && !w_apply);
      end
    end
    assign o_ce[g] = r_ce;
    assign w_pend[g] = r_pend;
  end
  // lock sequencer: any valid write restarts settling; counting pauses while a config is pending
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    if (w_we_ok) begin
      w_state_nxt = SETTLE;
      w_cnt_nxt = CNT_W'(LOCK_CYCLES - 1);
    end else if (r_state == SETTLE && !o_cfg_busy) begin
      if (r_cnt == '0) w_state_nxt = LOCKED;
      else w_cnt_nxt = r_cnt - 1'b1;
    end
  end
  // lock sequencer state register
  always_ff @(posedge i_refclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SETTLE;
      r_cnt <= CNT_W'(LOCK_CYCLES - 1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_clken_gen_frac.sv
// tb_clken_gen_frac: scoreboarded, table-driven bench for clken_gen_frac (3 channels, so an invalid channel is addressable)
module tb_clken_gen_frac;
  localparam int L = 1024;
  localparam int DINC[3] = '{26, 13, 1};
  localparam int DMOD[3] = '{27, 27, 3};
  logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, phase_sync = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [15:0] cfg_inc = '0, cfg_mod = '0;
  logic [2:0] o_ce;
  logic o_cfg_busy, o_locked;
  clken_gen_frac #(
    .NUM_CH(3), .ACC_W(16),
    .DEF_INC({16'd1, 16'd13, 16'd26}), .DEF_MOD({16'd3, 16'd27, 16'd27}),
    .LOCK_CYCLES(L)
  ) dut (
    .i_refclk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
    .i_cfg_inc(cfg_inc), .i_cfg_mod(cfg_mod), .i_phase_sync(phase_sync),
    .o_ce(o_ce), .o_cfg_busy(o_cfg_busy), .o_locked(o_locked)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [2:0] ce; logic busy; logic lock;} exp_t;
  typedef struct {int ch; int inc; int mod; int win; int exp_cnt;} vec_t;
  exp_t q[$];
  int n_vec = 0, n_bad = 0, cyc = 0;
  int cnt_ce[3];
  int m_acc[3], m_inc[3], m_mod[3], m_pinc[3], m_pmod[3], m_cnt;
  bit m_pend[3], m_ce[3], m_lock;
  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_acc[c] = 0; m_inc[c] = DINC[c]; m_mod[c] = DMOD[c];
      m_pinc[c] = 0; m_pmod[c] = 0; m_pend[c] = 0; m_ce[c] = 0;
    end
    m_cnt = L - 1; m_lock = 0;
  endtask
  task automatic model_step();
    bit busy_old = m_pend[0] | m_pend[1] | m_pend[2];
    for (int c = 0; c < 3; c++) begin
      bit clamp = (m_mod[c] == 0) || (m_inc[c] >= m_mod[c]);
      bit fire = 0, apply = 0;
      if (phase_sync) m_acc[c] = 0;
      else if (clamp) begin fire = 1; m_acc[c] = 0; end
      else if (m_inc[c] != 0) begin
        m_acc[c] += m_inc[c];
        fire = m_acc[c] >= m_mod[c];
        if (fire) m_acc[c] -= m_mod[c];
      end
      if (!phase_sync) apply = m_pend[c] && (fire || clamp || m_inc[c] == 0);
      m_ce[c] = fire;
      if (apply) begin m_inc[c] = m_pinc[c]; m_mod[c] = m_pmod[c]; m_pend[c] = 0; end
      if (cfg_we && cfg_ch == c) begin m_pinc[c] = cfg_inc; m_pmod[c] = cfg_mod; m_pend[c] = 1; end
    end
    if (cfg_we && cfg_ch < 3) begin m_lock = 0; m_cnt = L - 1; end
    else if (!m_lock && !busy_old) begin
      if (m_cnt == 0) m_lock = 1;
      else m_cnt--;
    end
  endtask
  function automatic bit pred_fire0();
    return m_mod[0] == 0 || m_inc[0] >= m_mod[0] || (m_inc[0] != 0 && m_acc[0] + m_inc[0] >= m_mod[0]);
  endfunction
  task automatic tick();
    exp_t e;
    if (!rst_n) model_reset(); else model_step();
    e.ce = {m_ce[2], m_ce[1], m_ce[0]};
    e.busy = m_pend[0] | m_pend[1] | m_pend[2];
    e.lock = m_lock;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    n_vec++;
    if ({o_ce, o_cfg_busy, o_locked} !== {e.ce, e.busy, e.lock}) begin
      n_bad++;
      $display("FAIL sb cyc %0d: got ce=%b busy=%b locked=%b, want ce=%b busy=%b locked=%b",
               cyc, o_ce, o_cfg_busy, o_locked, e.ce, e.busy, e.lock);
    end
    for (int c = 0; c < 3; c++) cnt_ce[c] += int'(o_ce[c]);
    cyc++;
    cfg_we = 0;
    phase_sync = 0;
  endtask
  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic clr_cnt();
    for (int c = 0; c < 3; c++) cnt_ce[c] = 0;
  endtask
  task automatic wr(input int ch, input int inc, input int mod);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_inc = 16'(inc); cfg_mod = 16'(mod);
  endtask
  task automatic wait_busy(output int n);
    n = 0;
    while (o_cfg_busy && n < 300) begin tick(); n++; end
    chk("busy clear bound", int'(o_cfg_busy), 0);
  endtask
  task automatic wait_lock();
    int n = 0;
    while (!o_locked && n < L + 100) begin tick(); n++; end
    chk("lock bound", int'(o_locked), 1);
  endtask
  initial begin
    vec_t tbl[8];
    int n, t;
    tbl = '{'{0, 3, 7, 70, 30}, '{2, 2, 5, 50, 20}, '{1, 26, 27, 54, 52}, '{0, 0, 0, 10, 10},
            '{2, 7, 3, 10, 10}, '{1, 0, 9, 30, 0}, '{2, 1, 3, 30, 10}, '{0, 1, 4, 40, 10}};
    model_reset();
    tick(); tick();
    chk("reset ce", int'(o_ce), 0);
    chk("reset busy", int'(o_cfg_busy), 0);
    chk("reset locked", int'(o_locked), 0);
    rst_n = 1;
    clr_cnt(); t = 0;
    for (int k = 1; k <= 2700; k++) begin
      tick();
      if (o_locked && t == 0) t = k;
    end
    chk("t1 lock time", t, L);
    chk("t1 ce0 pulses", cnt_ce[0], 2600);
    chk("t1 ce1 pulses", cnt_ce[1], 1300);
    chk("t1 ce2 pulses", cnt_ce[2], 900);
    chk("t2 locked before", int'(o_locked), 1);
    wr(0, 1, 4); tick();
    chk("t2 locked drop", int'(o_locked), 0);
    chk("t2 busy set", int'(o_cfg_busy), 1);
    wait_busy(n);
    chk("t2 apply on ce0", int'(o_ce[0]), 1);
    t = 0;
    for (int k = 1; k <= L + 50; k++) begin
      if (k == 101) clr_cnt();
      tick();
      if (k == 140) chk("t2 ce0 1-in-4", cnt_ce[0], 10);
      if (o_locked && t == 0) t = k;
    end
    chk("t2 relock time", t, L);
    wr(1, 5, 5); tick();
    wait_busy(n);
    clr_cnt();
    repeat (10) tick();
    chk("t3 clamp ce1", cnt_ce[1], 10);
    wr(1, 0, 9); tick();
    chk("t3 busy after write", int'(o_cfg_busy), 1);
    tick();
    chk("t3 disable applies next", int'(o_cfg_busy), 0);
    tick();
    clr_cnt();
    repeat (20) tick();
    chk("t3 disabled ce1", cnt_ce[1], 0);
    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].ch, tbl[i].inc, tbl[i].mod); tick();
      wait_busy(n);
      repeat (64) tick();
      clr_cnt();
      repeat (tbl[i].win) tick();
      chk($sformatf("vec%0d ch%0d %0d/%0d", i, tbl[i].ch, tbl[i].inc, tbl[i].mod), cnt_ce[tbl[i].ch], tbl[i].exp_cnt);
    end
    phase_sync = 1; wr(0, 2, 7); tick();
    phase_sync = 1; wr(0, 3, 7); tick();
    wait_busy(n);
    repeat (64) tick();
    clr_cnt();
    repeat (70) tick();
    chk("t4 last write wins", cnt_ce[0], 30);
    wait_lock();
    wr(3, 1, 2); tick();
    chk("t4 bad ch locked", int'(o_locked), 1);
    chk("t4 bad ch busy", int'(o_cfg_busy), 0);
    clr_cnt();
    repeat (70) tick();
    chk("t4 bad ch no effect", cnt_ce[0], 30);
    wr(0, 1, 2); tick();
    n = 0;
    while (!pred_fire0() && n < 20) begin tick(); n++; end
    phase_sync = 1; tick();
    chk("t5 sync ce", int'(o_ce), 0);
    chk("t5 sync holds apply", int'(o_cfg_busy), 1);
    wait_busy(n);
    chk("t5 apply delay", n, 3);
    chk("t5 apply on ce0", int'(o_ce[0]), 1);
    wr(0, 5, 9); tick();
    chk("t6 pending", int'(o_cfg_busy), 1);
    rst_n = 0;
    #1;
    chk("t6 async ce", int'(o_ce), 0);
    chk("t6 async busy", int'(o_cfg_busy), 0);
    chk("t6 async locked", int'(o_locked), 0);
    tick();
    rst_n = 1;
    clr_cnt();
    repeat (54) tick();
    chk("t6 ce0 default", cnt_ce[0], 52);
    chk("t6 ce1 default", cnt_ce[1], 26);
    chk("t6 ce2 default", cnt_ce[2], 18);
    chk("t6 no busy", int'(o_cfg_busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
